multi_compare: RTL and testbench
================================

// Module: multi_compare
// PURPOSE
//  Clocked, parametrised successor of the per-bit comparator cells.
//  Compares two WIDTH-bit operands MSB-first, DIGIT bits per cycle, and stops
//  early at the first differing digit. Supports unsigned and two's-complement
//  operands. Uses a req / return-to-zero handshake with one-hot finish flags.
//  Sits in the flow-control path and feeds branch/select logic.
// PARAMETERS
//  WIDTH  32  operand width in bits; WIDTH % DIGIT == 0 is required
//  DIGIT  4   bits compared per cycle; NDIG = WIDTH/DIGIT, NDIG >= 1
// PORTS
//  clk          in   1                clock; all logic on rising edge
//  rst          in   1                synchronous, active-high reset
//  req          in   1                compare request; held high until finish seen
//  signed_mode  in   1                1 = two's-complement compare, 0 = unsigned
//  x            in   WIDTH            operand X
//  y            in   WIDTH            operand Y
//  busy         out  1                high in SCAN
//  fin_equal    out  1                X == Y (one-hot with the two below)
//  fin_smaller  out  1                X < Y
//  fin_bigger   out  1                X > Y
//  digits       out  clog2(NDIG+1)    digits examined for the last result
// BEHAVIOUR
//  - Reset: state=IDLE; busy, fin_* = 0; digits = 0; index = 0.
//  - All outputs are registered.
//  - States and transitions:
//    IDLE, req=1 at edge E0: latch x, y and signed_mode; index = NDIG-1; go to SCAN.
//      In signed mode, bit WIDTH-1 of both latched operands is inverted
//      (offset binary), so the unsigned digit compare gives the signed order.
//    IDLE, req=0: stay in IDLE.
//    SCAN: each edge compares latched digit [index*DIGIT +: DIGIT].
//      Digits differ: set fin_bigger or fin_smaller; digits = NDIG-index; go to DONE.
//      Digits equal, index==0: set fin_equal; digits = NDIG; go to DONE.
//      Digits equal, otherwise: index = index-1.
//      req=0 in SCAN: abort; go to IDLE; no fin_* asserted; digits unchanged.
//    DONE: fin_* and digits hold while req=1. At an edge with req=0: clear fin_*;
//      go to IDLE.
//  - Latency: a difference at digit position p (0 = MSB) gives fin_* high
//    p+1 cycles after E0. Equal operands give fin_equal NDIG cycles after E0.
//  - x, y and signed_mode are ignored outside the E0 latch edge.
//  - A new compare needs req low for at least one edge (return-to-zero).
//    req held high after DONE never starts a second compare.
//  - At most one fin_* is high in any cycle. busy and fin_* are never high together.
//  - rst in any state beats req: next cycle IDLE, all outputs 0.
//  - NDIG=1: single-cycle SCAN; result 1 cycle after E0.
// TESTING  (WIDTH=8, DIGIT=2, NDIG=4 unless stated)
//  1 x=y=0xA5, unsigned, req held -> fin_equal high 4 cycles after E0; digits=4;
//    busy high for exactly 4 cycles.
//  2 x=0x80, y=0x7F, unsigned -> fin_bigger 1 cycle after E0, digits=1;
//    same operands with signed_mode=1 -> fin_smaller 1 cycle after E0, digits=1.
//  3 x=0x34, y=0x37 -> fin_smaller 4 cycles after E0, digits=4;
//    x=0xFF, y=0x00, signed -> fin_smaller 1 cycle after E0.
//  4 x=y=0x00, req dropped 2 cycles after E0 -> IDLE next edge; no fin_* ever;
//    busy low; next req starts a fresh compare.
//  5 In DONE, hold req 10 cycles while toggling x, y -> fin_* stable; req low ->
//    fin_* 0 next cycle; req high again -> new result for the new operands.
//  6 rst pulsed in SCAN and again in DONE -> next cycle all outputs 0, state IDLE;
//    random 1k vectors vs behavioural model, WIDTH/DIGIT = 8/1, 8/8, 32/4.

Source files
------------

// File: rtl/multi_compare.sv
// Digit-serial magnitude comparator: MSB-first, DIGIT bits per cycle, early exit
// on the first differing digit. req/return-to-zero handshake, one-hot finish flags.
//
// state | meaning
// IDLE  | waiting for req; operands latched on the edge that leaves
// SCAN  | comparing one digit per edge, MSB first
// DONE  | result and digit count held until req drops
module multi_compare #(
  parameter  int WIDTH = 32,
  parameter  int DIGIT = 4,
  localparam int NDIG  = WIDTH / DIGIT,
  localparam int DW    = $clog2(NDIG + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             fin_equal,
  output logic             fin_smaller,
  output logic             fin_bigger,
  output logic [DW-1:0]    digits
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}} ;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] xa, ya, xa_n, ya_n;
  logic [IW-1:0]    idx, idx_n;
  logic [DIGIT-1:0] dx, dy;
  logic             busy_n, eq_n, sm_n, bg_n;
  logic [DW-1:0]    dig_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      xa          <= '0;
      ya          <= '0;
      idx         <= '0;
      busy        <= 1'b0;
      fin_equal   <= 1'b0;
      fin_smaller <= 1'b0;
      fin_bigger  <= 1'b0;
      digits      <= '0;
    end else begin
      state       <= state_n;
      xa          <= xa_n;
      ya          <= ya_n;
      idx         <= idx_n;
      busy        <= busy_n;
      fin_equal   <= eq_n;
      fin_smaller <= sm_n;
      fin_bigger  <= bg_n;
      digits      <= dig_n;
    end
  end

  always_comb begin
    state_n = state;
    xa_n    = xa;
    ya_n    = ya;
    idx_n   = idx;
    eq_n    = fin_equal;
    sm_n    = fin_smaller;
    bg_n    = fin_bigger;
    dig_n   = digits;
    dx      = xa[idx*DIGIT +: DIGIT];
    dy      = ya[idx*DIGIT +: DIGIT];

    unique case (state)
      IDLE: begin
        if (req) begin
          // Flipping the sign bit maps two's-complement order onto unsigned order.
          xa_n    = x ^ (signed_mode ? MSB_MASK : '0);
          ya_n    = y ^ (signed_mode ? MSB_MASK : '0);
          idx_n   = IW'(NDIG - 1);
          state_n = SCAN;
        end
      end
      SCAN: begin
        if (!req) begin
          state_n = IDLE;
        end else if (dx != dy) begin
          bg_n    = (dx > dy);
          sm_n    = (dx < dy);
          dig_n   = DW'(NDIG) - DW'(idx);
          state_n = DONE;
        end else if (idx == '0) begin
          eq_n    = 1'b1;
          dig_n   = DW'(NDIG);
          state_n = DONE;
        end else begin
          idx_n = idx - IW'(1);
        end
      end
      DONE: begin
        if (!req) begin
          eq_n    = 1'b0;
          sm_n    = 1'b0;
          bg_n    = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == SCAN);
  end

endmodule

// File: tb/tb_multi_compare.sv
// Bench for multi_compare: directed steps on an 8/2 instance, then random vectors
// on 8/2, 8/1, 8/8 and 32/4 instances checked against an integer-order model.
module tb_multi_compare;

  logic        clk = 1'b0;
  logic        rst, req, signed_mode;
  logic [31:0] x, y;

  logic        b0, b1, b2, b3;
  logic [2:0]  f0, f1, f2, f3;
  logic [2:0]  d0;
  logic [3:0]  d1;
  logic [0:0]  d2;
  logic [3:0]  d3;

  logic        bsy [4];
  logic [2:0]  fin [4];
  int          dig [4];

  int          n_checks = 0;
  int          n_pass   = 0;
  int          lat  [4];
  int          bcnt [4];
  logic [31:0] ca, cb;
  logic        cs;

  localparam int W [4] = '{8, 8, 8, 32};
  localparam int D [4] = '{2, 1, 8, 4};

  always #5 clk = ~clk;

  multi_compare #(.WIDTH(8), .DIGIT(2)) u0 (
    .clk(clk), .rst(rst), .req(req), .signed_mode(signed_mode), .x(x[7:0]), .y(y[7:0]),
    .busy(b0), .fin_equal(f0[0]), .fin_smaller(f0[1]), .fin_bigger(f0[2]), .digits(d0));
  multi_compare #(.WIDTH(8), .DIGIT(1)) u1 (
    .clk(clk), .rst(rst), .req(req), .signed_mode(signed_mode), .x(x[7:0]), .y(y[7:0]),
    .busy(b1), .fin_equal(f1[0]), .fin_smaller(f1[1]), .fin_bigger(f1[2]), .digits(d1));
  multi_compare #(.WIDTH(8), .DIGIT(8)) u2 (
    .clk(clk), .rst(rst), .req(req), .signed_mode(signed_mode), .x(x[7:0]), .y(y[7:0]),
    .busy(b2), .fin_equal(f2[0]), .fin_smaller(f2[1]), .fin_bigger(f2[2]), .digits(d2));
  multi_compare #(.WIDTH(32), .DIGIT(4)) u3 (
    .clk(clk), .rst(rst), .req(req), .signed_mode(signed_mode), .x(x), .y(y),
    .busy(b3), .fin_equal(f3[0]), .fin_smaller(f3[1]), .fin_bigger(f3[2]), .digits(d3));

  always_comb begin
    bsy[0] = b0;  bsy[1] = b1;  bsy[2] = b2;  bsy[3] = b3;
    fin[0] = f0;  fin[1] = f1;  fin[2] = f2;  fin[3] = f3;
    dig[0] = int'(d0);  dig[1] = int'(d1);  dig[2] = int'(d2);  dig[3] = int'(d3);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Result code {bigger, smaller, equal} from integer order; digit count from the
  // highest differing bit position.
  function automatic void model(input int w, input int d, input logic [31:0] a,
                                input logic [31:0] b, input logic s,
                                output logic [2:0] f, output int dg);
    longint      va, vb;
    logic [31:0] m, diff;
    int          hb;
    m  = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    va = longint'(a & m);
    vb = longint'(b & m);
    if (s && a[w-1]) va = va - (longint'(1) << w);
    if (s && b[w-1]) vb = vb - (longint'(1) << w);
    f    = (va == vb) ? 3'b001 : (va < vb) ? 3'b010 : 3'b100;
    diff = (a ^ b) & m;
    hb   = -1;
    for (int k = 0; k < w; k++) if (diff[k]) hb = k;
    dg = (hb < 0) ? (w / d) : (w / d - hb / d);
  endfunction

  task automatic run_cmp(input logic [31:0] a, input logic [31:0] b, input logic s);
    x = a; y = b; signed_mode = s; req = 1'b1;
    ca = a; cb = b; cs = s;
    tick();
    for (int i = 0; i < 4; i++) begin
      lat[i]  = -1;
      bcnt[i] = bsy[i] ? 1 : 0;
    end
    x = $urandom; y = $urandom; signed_mode = ~s;
    for (int c = 1; c <= 12 && (lat[0] < 0 || lat[1] < 0 || lat[2] < 0 || lat[3] < 0); c++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        check($sformatf("inv%0d", i),
              32'(!(bsy[i] && fin[i] != 3'b000) && ($countones(fin[i]) <= 1)), 32'd1);
        if (bsy[i]) bcnt[i]++;
        if (lat[i] < 0 && fin[i] != 3'b000) lat[i] = c;
      end
    end
  endtask

  task automatic check_model();
    logic [2:0] ef;
    int         ed;
    for (int i = 0; i < 4; i++) begin
      model(W[i], D[i], ca, cb, cs, ef, ed);
      check($sformatf("fin%0d", i), 32'(fin[i]), 32'(ef));
      check($sformatf("dig%0d", i), dig[i], ed);
      check($sformatf("lat%0d", i), lat[i], ed);
      check($sformatf("busy_cycles%0d", i), bcnt[i], ed);
    end
  endtask

  task automatic release_req();
    int keep [4];
    for (int i = 0; i < 4; i++) keep[i] = dig[i];
    req = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rel_fin%0d", i), 32'(fin[i]), 32'd0);
      check($sformatf("rel_busy%0d", i), 32'(bsy[i]), 32'd0);
      check($sformatf("rel_dig%0d", i), dig[i], keep[i]);
    end
  endtask

  task automatic check_cleared(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_busy%0d", tag, i), 32'(bsy[i]), 32'd0);
      check($sformatf("%s_fin%0d", tag, i), 32'(fin[i]), 32'd0);
      check($sformatf("%s_dig%0d", tag, i), dig[i], 0);
    end
  endtask

  initial begin
    logic [31:0] a, b;
    rst = 1'b1; req = 1'b0; signed_mode = 1'b0; x = '0; y = '0;
    tick(); tick();
    rst = 1'b0;
    check_cleared("reset");

    // equal operands, full scan
    run_cmp(32'hA5, 32'hA5, 1'b0);
    check("t1_fin", 32'(fin[0]), 32'b001);
    check("t1_dig", dig[0], 4);
    check("t1_lat", lat[0], 4);
    check("t1_busy", bcnt[0], 4);
    check_model();
    release_req();

    run_cmp(32'h80, 32'h7F, 1'b0);
    check("t2u_fin", 32'(fin[0]), 32'b100);
    check("t2u_lat", lat[0], 1);
    check("t2u_dig", dig[0], 1);
    check_model();
    release_req();
    run_cmp(32'h80, 32'h7F, 1'b1);
    check("t2s_fin", 32'(fin[0]), 32'b010);
    check("t2s_lat", lat[0], 1);
    check("t2s_dig", dig[0], 1);
    check_model();
    release_req();

    run_cmp(32'h34, 32'h37, 1'b0);
    check("t3a_fin", 32'(fin[0]), 32'b010);
    check("t3a_lat", lat[0], 4);
    check("t3a_dig", dig[0], 4);
    check_model();
    release_req();
    run_cmp(32'hFF, 32'h00, 1'b1);
    check("t3b_fin", 32'(fin[0]), 32'b010);
    check("t3b_lat", lat[0], 1);
    check_model();
    release_req();

    // abort during scan
    x = 32'h0; y = 32'h0; signed_mode = 1'b0; req = 1'b1;
    tick(); tick(); tick();
    req = 1'b0;
    tick();
    check("t4_busy", 32'(bsy[0]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      check("t4_fin", 32'(fin[0]), 32'd0);
      tick();
    end
    run_cmp(32'h5C, 32'h5D, 1'b0);
    check("t4_fresh_fin", 32'(fin[0]), 32'b010);
    check("t4_fresh_dig", dig[0], 4);
    check_model();
    release_req();

    // hold in DONE while operands churn
    run_cmp(32'h12, 32'h34, 1'b0);
    check("t5_fin", 32'(fin[0]), 32'b010);
    check("t5_dig", dig[0], 2);
    for (int k = 0; k < 10; k++) begin
      x = $urandom; y = $urandom;
      tick();
      check("t5_hold_fin", 32'(fin[0]), 32'b010);
      check("t5_hold_dig", dig[0], 2);
      check("t5_hold_busy", 32'(bsy[0]), 32'd0);
    end
    release_req();
    run_cmp(32'h90, 32'h10, 1'b0);
    check("t5_new_fin", 32'(fin[0]), 32'b100);
    check("t5_new_dig", dig[0], 1);
    check_model();
    release_req();

    // reset in SCAN, then in DONE
    x = 32'h0; y = 32'h0; req = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
    check("t6_scan_busy", 32'(bsy[0]), 32'd0);
    check("t6_scan_fin", 32'(fin[0]), 32'd0);
    rst = 1'b0; req = 1'b0;
    tick();
    run_cmp(32'h80, 32'h7F, 1'b0);
    rst = 1'b1;
    tick();
    check_cleared("t6_done");
    rst = 1'b0; req = 1'b0;
    tick();

    for (int v = 0; v < 1000; v++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ (32'h1 << $urandom_range(0, 31));
        2: b = a ^ (32'h1 << $urandom_range(0, 7));
        default: ;
      endcase
      run_cmp(a, b, 1'($urandom_range(0, 1)));
      check_model();
      release_req();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
